// File: rtl/jt900h_pkg.sv
// jt900h_pkg: state encodings and format widths shared by the DIV/DIVS divider.
package jt900h_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_DIV, ST_FIX} div_st_t;
    localparam int DIV_BYTE_N = 8;
    localparam int DIV_WORD_N = 16;
endpackage

// File: rtl/jt900h_div_if.sv
// jt900h_div_if: start/operand request and busy/done/result response of the divider.
interface jt900h_div_if;
    logic        start;
    logic        sgn;
    logic        ws;
    logic [31:0] op0;
    logic [15:0] op1;
    logic        busy;
    logic        done;
    logic [31:0] rslt;
    logic        v;
    modport master (output start, sgn, ws, op0, op1, input busy, done, rslt, v);
    modport slave  (input start, sgn, ws, op0, op1, output busy, done, rslt, v);
endinterface

// File: rtl/jt900h_div_step.sv
// jt900h_div_step: one combinational restoring-division step for byte or word format.
module jt900h_div_step (
    input  logic [16:0] i_rem,
    input  logic [15:0] i_dvs,
    input  logic        i_bit,
    input  logic        i_ws,
    output logic [16:0] o_rem,
    output logic        o_q
);
    logic [17:0] w_sh, w_dv;
    assign w_sh  = i_ws ? {i_rem, i_bit} : {9'h0, i_rem[7:0], i_bit};
    assign w_dv  = i_ws ? {2'b0, i_dvs} : {10'h0, i_dvs[7:0]};
    assign o_q   = w_sh >= w_dv;
    assign o_rem = o_q ? 17'(w_sh - w_dv) : 17'(w_sh);
endmodule

// File: rtl/jt900h_div.sv
// jt900h_div: multi-cycle DIV/DIVS divider (16/8 byte and 32/16 word formats).
module jt900h_div
    import jt900h_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    jt900h_div_if.slave  bus
);
    div_st_t     r_st, w_st_nx;
    logic        r_sgn, r_ws, r_qs, r_rs, r_ovf, r_done, r_v;
    logic [31:0] r_op0, r_rslt;
    logic [15:0] r_op1, r_lo, r_dvs;
    logic [16:0] r_rem;
    logic [3:0]  r_cnt;
    logic        w_dnd_neg, w_dvs_neg, w_pre_ovf, w_qb, w_rng, w_ovf;
    logic [31:0] w_dnd_mag;
    logic [15:0] w_dvs_mag, w_hi, w_q, w_r, w_qf, w_rf;
    logic [16:0] w_rem_nx;
    assign w_dnd_neg = r_sgn & (r_ws ? r_op0[31] : r_op0[15]);
    assign w_dvs_neg = r_sgn & (r_ws ? r_op1[15] : r_op1[7]);
    assign w_dnd_mag = r_ws ? (w_dnd_neg ? -r_op0 : r_op0)
                            : {16'h0, w_dnd_neg ? -r_op0[15:0] : r_op0[15:0]};
    assign w_dvs_mag = r_ws ? (w_dvs_neg ? -r_op1 : r_op1)
                            : {8'h0, w_dvs_neg ? -r_op1[7:0] : r_op1[7:0]};
    assign w_hi      = r_ws ? w_dnd_mag[31:16] : {8'h0, w_dnd_mag[15:8]};
    // a zero divisor always trips this too, since w_hi >= 0
    assign w_pre_ovf = w_hi >= w_dvs_mag;
    jt900h_div_step u_step (
        .i_rem (r_rem),
        .i_dvs (r_dvs),
        .i_bit (r_ws ? r_lo[15] : r_lo[7]),
        .i_ws  (r_ws),
        .o_rem (w_rem_nx),
        .o_q   (w_qb)
    );
    assign w_q   = r_ws ? r_lo : {8'h0, r_lo[7:0]};
    assign w_r   = r_rem[15:0];
    assign w_qf  = r_qs ? -w_q : w_q;
    assign w_rf  = r_rs ? -w_r : w_r;
    assign w_rng = r_sgn & (r_ws ? (r_qs ? w_q > 16'h8000 : w_q > 16'h7fff)
                                 : (r_qs ? w_q > 16'h0080 : w_q > 16'h007f));
    assign w_ovf = r_ovf | w_rng;
    always_comb begin
        w_st_nx = r_st;
        case (r_st)
            ST_IDLE: w_st_nx = bus.start ? ST_PREP : ST_IDLE;
            ST_PREP: w_st_nx = w_pre_ovf ? ST_FIX : ST_DIV;
            ST_DIV:  w_st_nx = (r_cnt == 4'd0) ? ST_FIX : ST_DIV;
            default: w_st_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_st <= ST_IDLE;
        else if (cen)
            r_st <= w_st_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sgn  <= 1'b0;
            r_ws   <= 1'b0;
            r_op0  <= '0;
            r_op1  <= '0;
            r_rem  <= '0;
            r_lo   <= '0;
            r_dvs  <= '0;
            r_qs   <= 1'b0;
            r_rs   <= 1'b0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_v    <= 1'b0;
            r_rslt <= '0;
        end else if (cen) begin
            r_done <= r_st == ST_FIX;
            case (r_st)
                ST_IDLE: if (bus.start) begin
                    r_sgn <= bus.sgn;
                    r_ws  <= bus.ws;
                    r_op0 <= bus.op0;
                    r_op1 <= bus.op1;
                end
                ST_PREP: begin
                    r_rem <= {1'b0, w_hi};
                    r_lo  <= r_ws ? w_dnd_mag[15:0] : {8'h0, w_dnd_mag[7:0]};
                    r_dvs <= w_dvs_mag;
                    r_qs  <= w_dnd_neg ^ w_dvs_neg;
                    r_rs  <= w_dnd_neg;
                    r_ovf <= w_pre_ovf;
                    r_cnt <= r_ws ? 4'(DIV_WORD_N - 1) : 4'(DIV_BYTE_N - 1);
                end
                ST_DIV: begin
                    r_rem <= w_rem_nx;
                    r_lo  <= {r_lo[14:0], w_qb};
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_FIX: begin
                    r_v    <= w_ovf;
                    r_rslt <= w_ovf ? (r_ws ? r_op0 : {16'h0, r_op0[15:0]})
                                    : (r_ws ? {w_rf, w_qf} : {16'h0, w_rf[7:0], w_qf[7:0]});
                end
                default: ;
            endcase
        end
    end
    assign bus.busy = r_st != ST_IDLE;
    assign bus.done = r_done;
    assign bus.rslt = r_rslt;
    assign bus.v    = r_v;
endmodule

// File: tb/tb_jt900h_div.sv
// tb_jt900h_div: randomized and directed checks of jt900h_div against an arithmetic model.
module tb_jt900h_div;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;
    int   total = 0;
    int   bad = 0;
    jt900h_div_if bus ();
    jt900h_div dut (.clk(clk), .rst(rst), .cen(cen), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Expected result from plain integer division; SV / and % truncate toward zero.
    task automatic model(input logic s, input logic w, input logic [31:0] a0, input logic [15:0] b0,
                         output logic [31:0] er, output logic ev, output int el);
        longint a, b, q, r, mq, n;
        n = w ? 16 : 8;
        if (s) begin
            if (w) begin
                a = longint'($signed(a0));
                b = longint'($signed(b0));
            end else begin
                a = longint'($signed(a0[15:0]));
                b = longint'($signed(b0[7:0]));
            end
        end else begin
            a = w ? longint'(a0) : longint'(a0[15:0]);
            b = w ? longint'(b0) : longint'(b0[7:0]);
        end
        ev = 1'b0;
        el = int'(n) + 2;
        q = 0;
        r = 0;
        if (b == 0) begin
            ev = 1'b1;
            el = 2;
        end else begin
            mq = (a < 0 ? -a : a) / (b < 0 ? -b : b);
            if (mq >= (longint'(1) << n)) begin
                ev = 1'b1;
                el = 2;
            end else begin
                q = a / b;
                r = a % b;
                if (s && (q > (longint'(1) << (n - 1)) - 1 || q < -(longint'(1) << (n - 1))))
                    ev = 1'b1;
            end
        end
        if (ev)
            er = w ? a0 : {16'h0, a0[15:0]};
        else
            er = w ? {r[15:0], q[15:0]} : {16'h0, r[7:0], q[7:0]};
    endtask
    task automatic run(input logic s, input logic w, input logic [31:0] a0, input logic [15:0] b0,
                       input bit tog, input bit noise);
        logic [31:0] er;
        logic        ev;
        int          el, n;
        bit          got;
        model(s, w, a0, b0, er, ev, el);
        @(negedge clk);
        bus.sgn = s; bus.ws = w; bus.op0 = a0; bus.op1 = b0; bus.start = 1'b1; cen = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_on", bus.busy, 1);
        n = 0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            cen = tog ? (k % 2 == 1) : 1'b1;
            if (noise) begin
                bus.start = 1'($urandom % 2);
                bus.sgn   = 1'($urandom % 2);
                bus.ws    = 1'($urandom % 2);
                bus.op0   = $urandom;
                bus.op1   = 16'($urandom);
            end
            @(posedge clk);
            if (cen) n++;
            #1 got = bus.done;
            if (!got) check("busy_mid", bus.busy, 1);
        end
        bus.start = 1'b0;
        check("done_seen", got, 1);
        check("latency", n, el);
        check("rslt", bus.rslt, er);
        check("v", bus.v, ev);
        check("busy_off", bus.busy, 0);
        if (tog) begin
            @(negedge clk) cen = 1'b0;
            @(posedge clk);
            #1 check("done_hold", bus.done, 1);
        end
        @(negedge clk) cen = 1'b1;
        @(posedge clk);
        #1 check("done_pulse", bus.done, 0);
        check("rslt_hold", bus.rslt, er);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] a;
        logic [15:0] b;
        bus.start = 1'b0; bus.sgn = 1'b0; bus.ws = 1'b0; bus.op0 = '0; bus.op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_v", bus.v, 0);
        check("rst_rslt", bus.rslt, 0);
        @(negedge clk) rst = 1'b1;
        run(0, 0, 32'h0000_0064, 16'h0007, 0, 0);
        check("u8_spec", bus.rslt, 32'h0000_020E);
        run(1, 0, 32'h0000_FF9C, 16'h0007, 0, 0);
        check("s8_spec", bus.rslt, 32'h0000_FEF2);
        run(1, 0, 32'h0000_FF80, 16'h0001, 0, 0);
        check("s8_min", {bus.v, bus.rslt}, 33'h0_0000_0080);
        run(1, 0, 32'h0000_8000, 16'h00FF, 0, 0);
        check("s8_ovf", {bus.v, bus.rslt}, 33'h1_0000_8000);
        run(0, 1, 32'h0001_0000, 16'h0003, 0, 0);
        check("u16_spec", bus.rslt, 32'h0001_5555);
        run(0, 0, 32'h0000_1234, 16'h0000, 0, 0);
        check("div0", {bus.v, bus.rslt}, 33'h1_0000_1234);
        run(0, 0, 32'h0000_1234, 16'h0012, 0, 0);
        check("u8_ovf", bus.v, 1);
        run(1, 1, 32'h8000_0000, 16'hFFFF, 0, 0);
        run(1, 1, 32'hFFFF_8000, 16'h0001, 0, 0);
        run(1, 0, 32'h0000_0080, 16'h00FF, 0, 0);
        run(0, 1, 32'h0001_0000, 16'h0003, 0, 1);
        check("noise_ign", bus.rslt, 32'h0001_5555);
        run(0, 0, 32'h0000_0064, 16'h0007, 1, 0);
        check("cen_tog", bus.rslt, 32'h0000_020E);
        for (int i = 0; i < 60; i++) begin
            a = $urandom >> ($urandom % 32);
            b = 16'($urandom >> ($urandom % 24));
            run(1'($urandom % 2), 1'($urandom % 2), a, b, ($urandom % 4) == 0, ($urandom % 4) == 0);
        end
        run(0, 0, 32'h0000_0064, 16'h0007, 0, 0);
        @(negedge clk);
        bus.sgn = 1'b0; bus.ws = 1'b1; bus.op0 = 32'h0001_0000; bus.op1 = 16'h0003; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_v", bus.v, 0);
        check("abort_rslt", bus.rslt, 0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 check("no_done", {bus.done, bus.busy}, 2'b00);
        end
        run(0, 0, 32'h0000_0064, 16'h0007, 0, 0);
        check("post_rst", {bus.v, bus.rslt}, 33'h0_0000_020E);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
